branch_resolve_unit: RTL

//  Resolving end of the gshare front end. Carries each fetched instruction's prediction
//  (predicted next PC, taken bit, PHT pattern) down IF->ID->EX and compares it with the

---
 rtl/branch_resolve_unit.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - EX-stage branch resolution: flush/redirect, predictor update, perf counters
// Carries prediction metadata IF->ID->EX and checks it against the real outcome in EX.
module branch_resolve_unit #(
   parameter int PATTERN_W = 8,
   parameter int CNT_W     = 32
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_stall,
   input  logic                 i_IF_valid,
   input  logic                 i_IF_pred_taken,
   input  logic [31:0]          i_IF_pred_pc,
   input  logic [PATTERN_W-1:0] i_IF_pattern,
   input  logic [31:0]          i_EX_pc,
   input  logic [31:0]          i_EX_pc_four,
   input  logic [31:0]          i_EX_inst,
   input  logic [31:0]          i_alu_data,
   input  logic                 i_brc_taken,
   output logic                 o_flush,
   output logic [31:0]          o_redirect_pc,
   output logic                 o_upd_valid,
   output logic [31:0]          o_upd_pc,
   output logic                 o_upd_taken,
   output logic [31:0]          o_upd_target,
   output logic [PATTERN_W-1:0] o_upd_pattern,
   output logic [CNT_W-1:0]     o_brc_count,
   output logic [CNT_W-1:0]     o_miss_count
);

   localparam logic [4:0]       OP_BRANCH = 5'b11000;
   localparam logic [4:0]       OP_JAL    = 5'b11011;
   localparam logic [4:0]       OP_JALR   = 5'b11001;
   localparam logic [CNT_W-1:0] LP_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] LP_MAX    = {CNT_W{1'b1}};

   logic                 r_id_valid;
   logic                 r_id_pred_taken;
   logic [31:0]          r_id_pred_pc;
   logic [PATTERN_W-1:0] r_id_pattern;
   logic                 r_ex_valid;
   logic                 r_ex_pred_taken;
   logic [31:0]          r_ex_pred_pc;
   logic [PATTERN_W-1:0] r_ex_pattern;
   logic                 r_ex_done;

   logic                 r_upd_valid;
   logic [31:0]          r_upd_pc;
   logic                 r_upd_taken;
   logic [31:0]          r_upd_target;
   logic [PATTERN_W-1:0] r_upd_pattern;
   logic [CNT_W-1:0]     r_brc_count;
   logic [CNT_W-1:0]     r_miss_count;

   logic [4:0]  w_op;
   logic        w_is_b;
   logic        w_is_jal;
   logic        w_is_jalr;
   logic        w_is_ctrl;
   logic        w_taken;
   logic [31:0] w_target;
   logic [31:0] w_actual_next;
   logic        w_live;
   logic        w_mispredict;
   logic        w_flush;
   logic        w_resolve;
   logic        w_unused;

   assign w_op      = i_EX_inst[6:2];
   assign w_is_b    = (w_op == OP_BRANCH);
   assign w_is_jal  = (w_op == OP_JAL);
   assign w_is_jalr = (w_op == OP_JALR);
   assign w_is_ctrl = w_is_b | w_is_jal | w_is_jalr;

   assign w_taken       = w_is_jal | w_is_jalr | (w_is_b & i_brc_taken);
   assign w_target      = w_is_jalr ? {i_alu_data[31:1], 1'b0} : i_alu_data;
   assign w_actual_next = w_taken ? w_target : i_EX_pc_four;

   // r_ex_done blocks a stalled EX op from resolving (and counting) again
   assign w_live       = r_ex_valid & ~r_ex_done;
   assign w_mispredict = w_is_ctrl ? (w_actual_next != r_ex_pred_pc)
                                   : (r_ex_pred_pc != i_EX_pc_four);
   assign w_flush      = w_live & w_mispredict;
   assign w_resolve    = w_live & w_is_ctrl;

   assign o_flush       = w_flush;
   assign o_redirect_pc = r_ex_valid ? w_actual_next : 32'd0;

   assign w_unused = ^{i_EX_inst[31:7], i_EX_inst[1:0], i_EX_pc_four[1:0], r_ex_pred_taken};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_id_valid      <= 1'b0;
         r_id_pred_taken <= 1'b0;
         r_id_pred_pc    <= '0;
         r_id_pattern    <= '0;
         r_ex_valid      <= 1'b0;
         r_ex_pred_taken <= 1'b0;
         r_ex_pred_pc    <= '0;
         r_ex_pattern    <= '0;
         r_ex_done       <= 1'b0;
      end else if (w_flush) begin
         r_id_valid <= 1'b0;
         r_ex_valid <= 1'b0;
         r_ex_done  <= 1'b0;
      end else if (!i_stall) begin
         r_ex_valid      <= r_id_valid;
         r_ex_pred_taken <= r_id_pred_taken;
         r_ex_pred_pc    <= r_id_pred_pc;
         r_ex_pattern    <= r_id_pattern;
         r_ex_done       <= 1'b0;
         r_id_valid      <= i_IF_valid;
         r_id_pred_taken <= i_IF_pred_taken;
         r_id_pred_pc    <= i_IF_pred_pc;
         r_id_pattern    <= i_IF_pattern;
      end else if (r_ex_valid) begin
         r_ex_done <= 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_upd_valid   <= 1'b0;
         r_upd_pc      <= '0;
         r_upd_taken   <= 1'b0;
         r_upd_target  <= '0;
         r_upd_pattern <= '0;
      end else begin
         r_upd_valid <= w_resolve;
         if (w_resolve) begin
            r_upd_pc      <= i_EX_pc;
            r_upd_taken   <= w_taken;
            r_upd_target  <= w_target;
            r_upd_pattern <= r_ex_pattern;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_brc_count  <= '0;
         r_miss_count <= '0;
      end else begin
         if (w_resolve && (r_brc_count != LP_MAX)) begin
            r_brc_count <= r_brc_count + LP_ONE;
         end
         if (w_flush && (r_miss_count != LP_MAX)) begin
            r_miss_count <= r_miss_count + LP_ONE;
         end
      end
   end

   assign o_upd_valid   = r_upd_valid;
   assign o_upd_pc      = r_upd_pc;
   assign o_upd_taken   = r_upd_taken;
   assign o_upd_target  = r_upd_target;
   assign o_upd_pattern = r_upd_pattern;
   assign o_brc_count   = r_brc_count;
   assign o_miss_count  = r_miss_count;

endmodule
